// File: rtl/fft_frame_feeder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fft_frame_feeder_if : sample stream bus (valid/ready/last + payload)        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface fft_frame_feeder_if #(
   parameter int DATA_WIDTH = 16,
   parameter int MAX_STEP   = 9,
   parameter int FRAME_W    = 16
) ();
   logic                  o_valid;
   logic                  o_ready;
   logic                  o_last;
   logic [DATA_WIDTH-1:0] o_real;
   logic [DATA_WIDTH-1:0] o_imag;
   logic [MAX_STEP-1:0]   o_index;
   logic [FRAME_W-1:0]    o_frame;

   modport master (
      output o_valid, o_last, o_real, o_imag, o_index, o_frame,
      input  o_ready
   );

   modport slave (
      input  o_valid, o_last, o_real, o_imag, o_index, o_frame,
      output o_ready
   );
endinterface
`default_nettype wire

// File: rtl/fft_frame_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fft_frame_feeder : RAM-backed frame source streaming 2^step-point frames.  |
// | Optional FEEDER_BITREV_EN: bit-reversed RAM read order for DIT cores.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module fft_frame_feeder #(
   parameter int DATA_WIDTH = 16,
   parameter int MAX_STEP   = 9,
   parameter int FRAME_W    = 16
) (
   input  wire logic                  iclk,
   input  wire logic                  rstn,
   input  wire logic                  wr_en,
   input  wire logic [MAX_STEP-1:0]   wr_addr,
   input  wire logic [DATA_WIDTH-1:0] wr_real,
   input  wire logic [DATA_WIDTH-1:0] wr_imag,
   input  wire logic [3:0]            cfg_step,
   input  wire logic [FRAME_W-1:0]    cfg_frames,
   input  wire logic [7:0]            cfg_gap,
   input  wire logic                  start,
   input  wire logic                  abort,
   output logic                       busy,
   output logic                       done,
   fft_frame_feeder_if.master         m_axis
);

   localparam logic [2:0] c_IDLE   = 3'd0;
   localparam logic [2:0] c_PRIME  = 3'd1;
   localparam logic [2:0] c_STREAM = 3'd2;
   localparam logic [2:0] c_GAP    = 3'd3;
   localparam logic [2:0] c_DONE   = 3'd4;

   localparam logic [3:0] c_MAX_STEP = 4'(MAX_STEP);
   localparam int         c_DEPTH    = 1 << MAX_STEP;

   logic [2*DATA_WIDTH-1:0] r_ram [0:c_DEPTH-1];
   logic [2*DATA_WIDTH-1:0] r_rd_data;

   logic [2:0]          r_state;
   logic [MAX_STEP-1:0] r_cnt;
   logic                r_valid;
   logic                r_last;
   logic [FRAME_W-1:0]  r_frame;
   logic [7:0]          r_gap_cnt;
   logic                r_busy;
   logic                r_done;
   logic [3:0]          r_step;
   logic [FRAME_W-1:0]  r_frames;
   logic [7:0]          r_gap;

   logic [2:0]          w_nxt_state;
   logic [MAX_STEP-1:0] w_nxt_cnt;
   logic                w_nxt_valid;
   logic                w_nxt_last;
   logic [FRAME_W-1:0]  w_nxt_frame;
   logic [7:0]          w_nxt_gap_cnt;
   logic                w_nxt_busy;
   logic                w_nxt_done;
   logic                w_accept;
   logic [MAX_STEP-1:0] w_max;
   logic [FRAME_W-1:0]  w_frames_m1;
   logic [3:0]          w_step_clamped;
   logic [MAX_STEP-1:0] w_rd_addr;

   assign w_accept    = r_valid & m_axis.o_ready;
   assign w_max       = ~({MAX_STEP{1'b1}} << r_step);
   assign w_frames_m1 = r_frames - 1'b1;

   always_comb begin
      w_step_clamped = cfg_step;
      if (cfg_step == 4'd0)
         w_step_clamped = 4'd1;
      else if (cfg_step > c_MAX_STEP)
         w_step_clamped = c_MAX_STEP;
   end

   // w_nxt_cnt is the index that will be presented next cycle; the RAM is read
   // at that address every cycle so a stalled beat simply re-reads itself.
   always_comb begin
      w_nxt_state   = r_state;
      w_nxt_cnt     = '0;
      w_nxt_valid   = 1'b0;
      w_nxt_frame   = r_frame;
      w_nxt_gap_cnt = r_gap_cnt;
      w_nxt_busy    = r_busy;
      w_nxt_done    = 1'b0;
      case (r_state)
         c_IDLE: begin
            if (start) begin
               w_nxt_state = c_PRIME;
               w_nxt_busy  = 1'b1;
               w_nxt_frame = '0;
            end
         end
         c_PRIME: begin
            w_nxt_state = c_STREAM;
            w_nxt_valid = 1'b1;
         end
         c_STREAM: begin
            w_nxt_valid = 1'b1;
            w_nxt_cnt   = r_cnt;
            if (w_accept) begin
               if (!r_last) begin
                  w_nxt_cnt = r_cnt + 1'b1;
               end else begin
                  w_nxt_cnt   = '0;
                  w_nxt_frame = r_frame + 1'b1;
                  if ((r_frames != '0) && (r_frame == w_frames_m1)) begin
                     w_nxt_state = c_DONE;
                     w_nxt_valid = 1'b0;
                     w_nxt_busy  = 1'b0;
                     w_nxt_done  = 1'b1;
                  end else if (r_gap != 8'd0) begin
                     w_nxt_state   = c_GAP;
                     w_nxt_valid   = 1'b0;
                     w_nxt_gap_cnt = r_gap;
                  end
               end
            end
         end
         c_GAP: begin
            w_nxt_gap_cnt = r_gap_cnt - 1'b1;
            if (r_gap_cnt == 8'd1) begin
               w_nxt_state = c_STREAM;
               w_nxt_valid = 1'b1;
            end
         end
         c_DONE: begin
            w_nxt_state = c_IDLE;
         end
         default: begin
            w_nxt_state = c_IDLE;
         end
      endcase
      if (abort) begin
         w_nxt_state = c_IDLE;
         w_nxt_valid = 1'b0;
         w_nxt_busy  = 1'b0;
         w_nxt_done  = 1'b0;
         w_nxt_cnt   = '0;
      end
   end

   assign w_nxt_last = w_nxt_valid & (w_nxt_cnt == w_max);

`ifdef FEEDER_BITREV_EN
   function automatic logic [MAX_STEP-1:0] f_bitrev(input logic [MAX_STEP-1:0] a,
                                                    input logic [3:0]          s);
      logic [MAX_STEP-1:0] v;
      v = '0;
      for (int i = 0; i < MAX_STEP; i++) begin
         if (i < int'(s))
            v[i] = a[int'(s) - 1 - i];
      end
      return v;
   endfunction

   assign w_rd_addr = f_bitrev(w_nxt_cnt, r_step);
`else
   assign w_rd_addr = w_nxt_cnt;
`endif

   always_ff @(posedge iclk or negedge rstn) begin
      if (!rstn) begin
         r_state   <= c_IDLE;
         r_cnt     <= '0;
         r_valid   <= 1'b0;
         r_last    <= 1'b0;
         r_frame   <= '0;
         r_gap_cnt <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_step    <= 4'd1;
         r_frames  <= '0;
         r_gap     <= '0;
      end else begin
         r_state   <= w_nxt_state;
         r_cnt     <= w_nxt_cnt;
         r_valid   <= w_nxt_valid;
         r_last    <= w_nxt_last;
         r_frame   <= w_nxt_frame;
         r_gap_cnt <= w_nxt_gap_cnt;
         r_busy    <= w_nxt_busy;
         r_done    <= w_nxt_done;
         if ((r_state == c_IDLE) && start) begin
            r_step   <= w_step_clamped;
            r_frames <= cfg_frames;
            r_gap    <= cfg_gap;
         end
      end
   end

   // Writes are blocked while busy so a stalled beat's re-read stays stable.
   always_ff @(posedge iclk) begin
      if (wr_en && !r_busy)
         r_ram[wr_addr] <= {wr_real, wr_imag};
   end

   always_ff @(posedge iclk or negedge rstn) begin
      if (!rstn)
         r_rd_data <= '0;
      else
         r_rd_data <= r_ram[w_rd_addr];
   end

   assign busy           = r_busy;
   assign done           = r_done;
   assign m_axis.o_valid = r_valid;
   assign m_axis.o_last  = r_last;
   assign m_axis.o_real  = r_rd_data[2*DATA_WIDTH-1:DATA_WIDTH];
   assign m_axis.o_imag  = r_rd_data[DATA_WIDTH-1:0];
   assign m_axis.o_index = r_cnt;
   assign m_axis.o_frame = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fft_frame_feeder : directed self-checking bench for fft_frame_feeder    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_fft_frame_feeder;

   logic        iclk = 1'b0;
   logic        rstn;
   logic        wr_en;
   logic [8:0]  wr_addr;
   logic [15:0] wr_real;
   logic [15:0] wr_imag;
   logic [3:0]  cfg_step;
   logic [15:0] cfg_frames;
   logic [7:0]  cfg_gap;
   logic        start;
   logic        abort;
   logic        busy;
   logic        done;

   int checks = 0;
   int errors = 0;

   int q_real[$], q_imag[$], q_idx[$], q_frm[$], q_last[$], q_cyc[$];
   int n_done, done_cyc, stall_viol, post_valid;
   bit timed_out, busy_at_start, busy_at_done, busy_end;

   fft_frame_feeder_if #(.DATA_WIDTH(16), .MAX_STEP(9), .FRAME_W(16)) bus ();

   fft_frame_feeder #(.DATA_WIDTH(16), .MAX_STEP(9), .FRAME_W(16)) dut (
      .iclk       (iclk),
      .rstn       (rstn),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_real    (wr_real),
      .wr_imag    (wr_imag),
      .cfg_step   (cfg_step),
      .cfg_frames (cfg_frames),
      .cfg_gap    (cfg_gap),
      .start      (start),
      .abort      (abort),
      .busy       (busy),
      .done       (done),
      .m_axis     (bus)
   );

   always #5 iclk = ~iclk;

   // RAM address expected for sample k of a 2^s frame
   function automatic int exp_addr(input int k, input int s);
      int r;
`ifdef FEEDER_BITREV_EN
      r = 0;
      for (int i = 0; i < s; i++) r |= ((k >> (s - 1 - i)) & 1) << i;
`else
      r = k;
`endif
      return r;
   endfunction

   task automatic fill_ram;
      for (int i = 0; i < 64; i++) begin
         wr_en = 1'b1; wr_addr = 9'(i); wr_real = 16'(i); wr_imag = 16'(-i);
         @(posedge iclk); #1;
      end
      wr_en = 1'b0;
   endtask

   task automatic run(input int step, input int frames, input int gap, input int pct,
                      input int abort_beat, input bit wr_busy, input int max_cyc);
      int  beats = 0;
      int  tail = 0;
      bit  fin = 0;
      bit  stall = 0;
      logic [59:0] saved = '0;
      q_real.delete(); q_imag.delete(); q_idx.delete();
      q_frm.delete(); q_last.delete(); q_cyc.delete();
      n_done = 0; done_cyc = -1; stall_viol = 0; post_valid = 0; timed_out = 0;
      busy_at_done = 1'b1;
      cfg_step = 4'(step); cfg_frames = 16'(frames); cfg_gap = 8'(gap); start = 1'b1;
      @(posedge iclk); #1;
      start = 1'b0;
      busy_at_start = busy;
      for (int c = 0; c < max_cyc; c++) begin
         if (stall && ({bus.o_valid, bus.o_last, bus.o_real, bus.o_imag, bus.o_index, bus.o_frame} !== saved))
            stall_viol++;
         if (fin) begin
            bus.o_ready = 1'b1;
            if (bus.o_valid) post_valid++;
            if (done) n_done++;
            tail++;
            if (tail > 4) break;
         end else if (done) begin
            n_done++; done_cyc = c; busy_at_done = busy; fin = 1;
            if (bus.o_valid) post_valid++;
         end else if (abort_beat >= 0 && beats == abort_beat && bus.o_valid) begin
            abort = 1'b1; bus.o_ready = 1'b1; fin = 1;
         end else begin
            bus.o_ready = ($urandom_range(0, 99) < pct);
            if (bus.o_valid && bus.o_ready) begin
               q_real.push_back(int'(bus.o_real)); q_imag.push_back(int'(bus.o_imag));
               q_idx.push_back(int'(bus.o_index)); q_frm.push_back(int'(bus.o_frame));
               q_last.push_back(int'(bus.o_last)); q_cyc.push_back(c);
               beats++;
            end
         end
         if (wr_busy && c == 0) begin
            wr_en = 1'b1; wr_addr = 9'd3; wr_real = 16'hDEAD; wr_imag = 16'hBEEF;
            start = 1'b1; cfg_step = 4'd2;
         end
         stall = !fin && bus.o_valid && !bus.o_ready;
         saved = {bus.o_valid, bus.o_last, bus.o_real, bus.o_imag, bus.o_index, bus.o_frame};
         @(posedge iclk); #1;
         abort = 1'b0; wr_en = 1'b0; start = 1'b0; cfg_step = 4'(step);
      end
      if (!fin || tail <= 4) timed_out = 1;
      busy_end = busy;
      bus.o_ready = 1'b1;
   endtask

   task automatic test_reset;
      rstn = 1'b0;
      repeat (3) @(posedge iclk);
      #1;
      checks++;
      if ({bus.o_valid, bus.o_last, bus.o_real, bus.o_imag, bus.o_index, bus.o_frame, busy, done} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got valid=%b last=%b real=%h imag=%h idx=%0d frame=%0d busy=%b done=%b, expected all 0",
                  bus.o_valid, bus.o_last, bus.o_real, bus.o_imag, bus.o_index, bus.o_frame, busy, done);
      end
      @(negedge iclk); rstn = 1'b1;
      @(posedge iclk); #1;
      checks++;
      if ({bus.o_valid, busy, done} !== 3'b000) begin
         errors++;
         $display("FAIL reset_release: got valid/busy/done=%b, expected 000", {bus.o_valid, busy, done});
      end
   endtask

   task automatic test_single_frame(input int pct);
      run(6, 1, 0, pct, -1, 0, 400);
      checks++;
      if (timed_out !== 1'b0 || q_real.size() !== 64) begin
         errors++;
         $display("FAIL single_beats pct=%0d: got %0d beats timeout=%b, expected 64 beats", pct, q_real.size(), timed_out);
      end
      for (int k = 0; k < q_real.size() && k < 64; k++) begin
         int a = exp_addr(k, 6);
         checks++;
         if (q_real[k] !== a || q_imag[k] !== ((-a) & 32'hFFFF) || q_idx[k] !== k ||
             q_last[k] !== int'(k == 63) || q_frm[k] !== 0) begin
            errors++;
            $display("FAIL single_beat%0d pct=%0d: got real=%0d imag=%0d idx=%0d last=%0d frame=%0d, expected real=%0d imag=%0d idx=%0d last=%0d frame=0",
                     k, pct, q_real[k], q_imag[k], q_idx[k], q_last[k], q_frm[k], a, (-a) & 32'hFFFF, k, int'(k == 63));
         end
      end
      checks++;
      if (busy_at_start !== 1'b1) begin
         errors++; $display("FAIL busy_after_start: got %b expected 1", busy_at_start);
      end
      if (pct == 100 && q_cyc.size() == 64) begin
         checks++;
         if (q_cyc[0] !== 1 || q_cyc[63] !== 64) begin
            errors++;
            $display("FAIL beat_timing: got first=%0d last=%0d, expected first=1 last=64", q_cyc[0], q_cyc[63]);
         end
      end
      if (q_cyc.size() == 64) begin
         checks++;
         if (done_cyc !== q_cyc[63] + 1) begin
            errors++; $display("FAIL done_timing: got cycle %0d expected %0d", done_cyc, q_cyc[63] + 1);
         end
      end
      checks++;
      if (n_done !== 1 || busy_at_done !== 1'b0 || post_valid !== 0 || stall_viol !== 0) begin
         errors++;
         $display("FAIL single_end pct=%0d: got done_pulses=%0d busy_at_done=%b post_valid=%0d stall_changes=%0d, expected 1 0 0 0",
                  pct, n_done, busy_at_done, post_valid, stall_viol);
      end
   endtask

   task automatic test_gapped_frames;
      run(3, 3, 2, 100, -1, 0, 200);
      checks++;
      if (q_real.size() !== 24 || timed_out !== 1'b0) begin
         errors++; $display("FAIL gap_beats: got %0d beats timeout=%b, expected 24", q_real.size(), timed_out);
      end
      for (int k = 0; k < q_real.size() && k < 24; k++) begin
         int a = exp_addr(k % 8, 3);
         int dc = (k == 0) ? 1 : ((k % 8 == 0) ? 3 : 1);
         int got_dc = (k == 0) ? q_cyc[0] : q_cyc[k] - q_cyc[k-1];
         checks++;
         if (q_real[k] !== a || q_idx[k] !== k % 8 || q_frm[k] !== k / 8 ||
             q_last[k] !== int'(k % 8 == 7) || got_dc !== dc) begin
            errors++;
            $display("FAIL gap_beat%0d: got real=%0d idx=%0d frame=%0d last=%0d spacing=%0d, expected %0d %0d %0d %0d %0d",
                     k, q_real[k], q_idx[k], q_frm[k], q_last[k], got_dc, a, k % 8, k / 8, int'(k % 8 == 7), dc);
         end
      end
      checks++;
      if (n_done !== 1 || post_valid !== 0) begin
         errors++; $display("FAIL gap_done: got pulses=%0d post_valid=%0d, expected 1 0", n_done, post_valid);
      end
   endtask

   task automatic test_back_to_back;
      run(2, 2, 0, 100, -1, 0, 100);
      checks++;
      if (q_real.size() !== 8) begin
         errors++; $display("FAIL b2b_beats: got %0d expected 8", q_real.size());
      end
      for (int k = 0; k < q_real.size() && k < 8; k++) begin
         checks++;
         if (q_cyc[k] !== k + 1 || q_frm[k] !== k / 4 || q_idx[k] !== k % 4) begin
            errors++;
            $display("FAIL b2b_beat%0d: got cyc=%0d frame=%0d idx=%0d, expected %0d %0d %0d",
                     k, q_cyc[k], q_frm[k], q_idx[k], k + 1, k / 4, k % 4);
         end
      end
   endtask

   task automatic test_continuous_abort;
      run(4, 0, 0, 100, 37, 0, 200);
      checks++;
      if (q_real.size() !== 37) begin
         errors++; $display("FAIL cont_beats: got %0d expected 37", q_real.size());
      end
      for (int k = 0; k < q_real.size() && k < 37; k++) begin
         checks++;
         if (q_real[k] !== exp_addr(k % 16, 4) || q_frm[k] !== k / 16 || q_last[k] !== int'(k % 16 == 15)) begin
            errors++;
            $display("FAIL cont_beat%0d: got real=%0d frame=%0d last=%0d, expected %0d %0d %0d",
                     k, q_real[k], q_frm[k], q_last[k], exp_addr(k % 16, 4), k / 16, int'(k % 16 == 15));
         end
      end
      checks++;
      if (n_done !== 0 || post_valid !== 0 || busy_end !== 1'b0 || timed_out !== 1'b0) begin
         errors++;
         $display("FAIL abort_effect: got done_pulses=%0d valid_after=%0d busy=%b timeout=%b, expected 0 0 0 0",
                  n_done, post_valid, busy_end, timed_out);
      end
      run(1, 1, 0, 100, -1, 0, 50);
      checks++;
      if (q_real.size() !== 2 || n_done !== 1) begin
         errors++; $display("FAIL restart_after_abort: got beats=%0d done=%0d, expected 2 1", q_real.size(), n_done);
      end
   endtask

   task automatic test_write_while_busy;
      run(5, 1, 0, 100, -1, 1, 200);
      checks++;
      if (q_real.size() !== 32) begin
         errors++; $display("FAIL busy_cfg_ignored: got %0d beats expected 32", q_real.size());
      end
      for (int k = 0; k < q_real.size() && k < 32; k++) begin
         int a = exp_addr(k, 5);
         checks++;
         if (q_real[k] !== a || q_imag[k] !== ((-a) & 32'hFFFF)) begin
            errors++;
            $display("FAIL ram_intact_beat%0d: got real=%0d imag=%0d, expected %0d %0d", k, q_real[k], q_imag[k], a, (-a) & 32'hFFFF);
         end
      end
   endtask

   task automatic test_async_reset;
      int  beats = 0;
      bit  hit = 0;
      cfg_step = 4'd5; cfg_frames = 16'd1; cfg_gap = 8'd0; start = 1'b1; bus.o_ready = 1'b1;
      @(posedge iclk); #1;
      start = 1'b0;
      for (int c = 0; c < 100; c++) begin
         if (bus.o_valid && beats == 10) begin hit = 1; break; end
         if (bus.o_valid) beats++;
         @(posedge iclk); #1;
      end
      checks++;
      if (hit !== 1'b1 || bus.o_index !== 9'd10) begin
         errors++; $display("FAIL midframe_reach: got reached=%b idx=%0d, expected 1 10", hit, bus.o_index);
      end
      #2 rstn = 1'b0;
      #1;
      checks++;
      if ({bus.o_valid, bus.o_last, bus.o_real, bus.o_imag, bus.o_index, bus.o_frame, busy, done} !== '0) begin
         errors++;
         $display("FAIL async_reset: got valid=%b real=%h idx=%0d busy=%b, expected all 0",
                  bus.o_valid, bus.o_real, bus.o_index, busy);
      end
      @(negedge iclk); rstn = 1'b1;
      repeat (3) @(posedge iclk);
      #1;
      checks++;
      if ({bus.o_valid, busy} !== 2'b00) begin
         errors++; $display("FAIL no_autorestart: got valid/busy=%b expected 00", {bus.o_valid, busy});
      end
   endtask

   task automatic test_step_clamp;
      run(0, 1, 0, 100, -1, 0, 50);
      checks++;
      if (q_real.size() !== 2 || q_last.size() != 2 || q_last[0] !== 0 || q_last[1] !== 1 ||
          q_real[0] !== exp_addr(0, 1) || q_real[1] !== exp_addr(1, 1)) begin
         errors++; $display("FAIL step0_clamp: got %0d beats, expected 2 with last on second", q_real.size());
      end
      run(3, 1, 0, 100, -1, 0, 50);
      for (int k = 0; k < q_real.size() && k < 8; k++) begin
         checks++;
         if (q_real[k] !== exp_addr(k, 3)) begin
            errors++; $display("FAIL order_step3_beat%0d: got %0d expected %0d", k, q_real[k], exp_addr(k, 3));
         end
      end
      run(15, 1, 0, 100, -1, 0, 700);
      checks++;
      if (q_idx.size() !== 512 || q_idx[q_idx.size()-1] !== 511 || q_last[q_last.size()-1] !== 1 || n_done !== 1) begin
         errors++;
         $display("FAIL step_max_clamp: got %0d beats done=%0d, expected 512 beats ending at 511 with last", q_idx.size(), n_done);
      end
   endtask

   initial begin
      rstn = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_real = '0; wr_imag = '0;
      cfg_step = '0; cfg_frames = '0; cfg_gap = '0; start = 1'b0; abort = 1'b0;
      bus.o_ready = 1'b0;
      test_reset();
      fill_ram();
      test_single_frame(100);
      test_single_frame(50);
      test_gapped_frames();
      test_back_to_back();
      test_continuous_abort();
      test_write_while_busy();
      test_async_reset();
      test_step_clamp();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
